// File: rtl/l1_pmem_arbiter_if.sv
// Bundles the two L1 cache ports and the shared pmem port seen by l1_pmem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives the caches and memory.
interface l1_pmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
);
  logic                  icache_pmem_read;
  logic                  icache_pmem_write;
  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_wdata;
  logic                  icache_pmem_resp;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;

  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic                  dcache_pmem_resp;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  modport slave (
    input  icache_pmem_read, icache_pmem_write, icache_pmem_address, icache_pmem_wdata,
    output icache_pmem_resp, icache_pmem_rdata,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_resp, dcache_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output icache_pmem_read, icache_pmem_write, icache_pmem_address, icache_pmem_wdata,
    input  icache_pmem_resp, icache_pmem_rdata,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_resp, dcache_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/l1_pmem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache for a single pmem port.
// One transaction is granted at a time; the response is routed back only to the granted cache.
module l1_pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input logic               clk,
  input logic               reset,
  l1_pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StRelease} state_e;

  state_e state_q, state_d;
  logic   last_served_q, last_served_d;  // 0 = I-cache, 1 = D-cache

  logic i_req, d_req;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  icache_resp;
  logic                  dcache_resp;

  assign i_req = bus.icache_pmem_read | bus.icache_pmem_write;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = last_served_q ? StGrantI : StGrantD;
        end else if (i_req) begin
          state_d = StGrantI;
        end else if (d_req) begin
          state_d = StGrantD;
        end
      end
      StGrantI: begin
        if (bus.pmem_resp) begin
          state_d       = StRelease;
          last_served_d = 1'b0;
        end else if (!i_req) begin
          state_d = StIdle;
        end
      end
      StGrantD: begin
        if (bus.pmem_resp) begin
          state_d       = StRelease;
          last_served_d = 1'b1;
        end else if (!d_req) begin
          state_d = StIdle;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  // Write wins over read so pmem never sees both strobes together.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    case (state_q)
      StGrantI: begin
        pmem_write   = bus.icache_pmem_write;
        pmem_read    = bus.icache_pmem_read & ~bus.icache_pmem_write;
        pmem_address = bus.icache_pmem_address;
        pmem_wdata   = bus.icache_pmem_wdata;
        icache_resp  = bus.pmem_resp;
      end
      StGrantD: begin
        pmem_write   = bus.dcache_pmem_write;
        pmem_read    = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
        pmem_address = bus.dcache_pmem_address;
        pmem_wdata   = bus.dcache_pmem_wdata;
        dcache_resp  = bus.pmem_resp;
      end
      default: ;
    endcase
    // Explicit gate keeps the strobes low the instant reset asserts.
    if (reset) begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      icache_resp  = 1'b0;
      dcache_resp  = 1'b0;
    end
  end

  assign bus.pmem_read         = pmem_read;
  assign bus.pmem_write        = pmem_write;
  assign bus.pmem_address      = pmem_address;
  assign bus.pmem_wdata        = pmem_wdata;
  assign bus.icache_pmem_resp  = icache_resp;
  assign bus.dcache_pmem_resp  = dcache_resp;
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Directed bench for l1_pmem_arbiter: inputs change on the falling edge and outputs are
// checked 1 time unit later, well away from the rising edge.
module tb_l1_pmem_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   waited;

  l1_pmem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

  l1_pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0]  seq_addr [4];
  logic [127:0] line_a5;
  logic [127:0] line_11;
  logic [127:0] line_de;
  logic [127:0] line_55;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    waited   = 0;
    seq_addr = '{16'h0100, 16'h0200, 16'h0100, 16'h0200};
    line_a5  = {16{8'hA5}};
    line_11  = {8{16'h1111}};
    line_de  = {4{32'hDEADBEEF}};
    line_55  = {8{16'h5555}};

    reset                   = 1'b1;
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_write   = 1'b0;
    bus.icache_pmem_address = '0;
    bus.icache_pmem_wdata   = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.pmem_resp           = 1'b0;
    bus.pmem_rdata          = '0;

    // Reset state
    @(negedge clk); #1;
    chk1("rst_pmem_read", bus.pmem_read, 1'b0);
    chk1("rst_pmem_write", bus.pmem_write, 1'b0);
    chk1("rst_iresp", bus.icache_pmem_resp, 1'b0);
    chk1("rst_dresp", bus.dcache_pmem_resp, 1'b0);
    @(negedge clk); reset = 1'b0; #1;
    chk1("rst_deassert_read", bus.pmem_read, 1'b0);

    // 1: lone I-cache read, memory replies 3 cycles after the grant
    @(negedge clk);
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1230;
    #1 chk1("s1_req_cycle_read", bus.pmem_read, 1'b0);
    @(negedge clk); #1;
    chk1("s1_grant_read", bus.pmem_read, 1'b1);
    chk1("s1_grant_write", bus.pmem_write, 1'b0);
    chka("s1_grant_addr", bus.pmem_address, 16'h1230);
    repeat (2) begin
      @(negedge clk); #1;
      chk1("s1_wait_iresp", bus.icache_pmem_resp, 1'b0);
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_a5;
    #1;
    chk1("s1_iresp", bus.icache_pmem_resp, 1'b1);
    chkd("s1_irdata", bus.icache_pmem_rdata, line_a5);
    chk1("s1_dresp", bus.dcache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    chk1("s1_release_read", bus.pmem_read, 1'b0);
    chk1("s1_release_iresp", bus.icache_pmem_resp, 1'b0);
    @(negedge clk); #1;
    chk1("s1_idle_iresp", bus.icache_pmem_resp, 1'b0);

    // 2: simultaneous I read / D write right after reset, I wins the first tie
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    reset                   = 1'b0;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h0040;
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h8000;
    bus.dcache_pmem_wdata   = line_11;
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_a5;
    #1;
    chk1("s2_i_read", bus.pmem_read, 1'b1);
    chk1("s2_i_write", bus.pmem_write, 1'b0);
    chka("s2_i_addr", bus.pmem_address, 16'h0040);
    chk1("s2_iresp", bus.icache_pmem_resp, 1'b1);
    chk1("s2_dresp_during_i", bus.dcache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    chk1("s2_release_write", bus.pmem_write, 1'b0);
    chk1("s2_release_dresp", bus.dcache_pmem_resp, 1'b0);
    @(negedge clk); #1;
    chk1("s2_idle_write", bus.pmem_write, 1'b0);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk1("s2_d_write", bus.pmem_write, 1'b1);
    chk1("s2_d_read", bus.pmem_read, 1'b0);
    chka("s2_d_addr", bus.pmem_address, 16'h8000);
    chkd("s2_d_wdata", bus.pmem_wdata, line_11);
    chk1("s2_dresp", bus.dcache_pmem_resp, 1'b1);
    chk1("s2_iresp_during_d", bus.icache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.pmem_resp         = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    #1 chk1("s2_after_dresp", bus.dcache_pmem_resp, 1'b0);
    @(negedge clk);

    // 3: both request continuously, grants alternate I, D, I, D
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h0100;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      waited = 0;
      while (!bus.pmem_read && waited < 6) begin
        @(negedge clk); #1;
        waited++;
      end
      chk1("s3_grant_seen", bus.pmem_read, 1'b1);
      chka("s3_grant_addr", bus.pmem_address, seq_addr[k]);
      chka("s3_wait_cycles", 16'(waited), (k == 0) ? 16'd0 : 16'd2);
      bus.pmem_resp = 1'b1;
      #1;
      chk1("s3_iresp", bus.icache_pmem_resp, (k % 2) == 0);
      chk1("s3_dresp", bus.dcache_pmem_resp, (k % 2) == 1);
    end
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    @(negedge clk);

    // 4: D-cache read and write together, write wins
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h2000;
    bus.dcache_pmem_wdata   = line_de;
    @(negedge clk); #1;
    chk1("s4_write", bus.pmem_write, 1'b1);
    chk1("s4_read", bus.pmem_read, 1'b0);
    chka("s4_addr", bus.pmem_address, 16'h2000);
    chkd("s4_wdata", bus.pmem_wdata, line_de);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1 chk1("s4_dresp", bus.dcache_pmem_resp, 1'b1);
    chk1("s4_iresp", bus.icache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.pmem_resp         = 1'b0;
    bus.dcache_pmem_read  = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    @(negedge clk);

    // 5: reset asserted mid-GRANT_D, two cycles before pmem_resp
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h3000;
    bus.dcache_pmem_wdata   = line_55;
    @(negedge clk); #1;
    chk1("s5_granted_write", bus.pmem_write, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("s5_reset_drops_write", bus.pmem_write, 1'b0);
    chka("s5_reset_addr", bus.pmem_address, 16'h0000);
    @(negedge clk);
    reset                 = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    #1 chk1("s5_deassert_write", bus.pmem_write, 1'b0);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk1("s5_stale_dresp", bus.dcache_pmem_resp, 1'b0);
    chk1("s5_stale_iresp", bus.icache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.pmem_resp           = 1'b0;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h0500;
    #1 chk1("s5_idle_read", bus.pmem_read, 1'b0);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk1("s5_post_reset_grant", bus.pmem_read, 1'b1);
    chka("s5_post_reset_addr", bus.pmem_address, 16'h0500);
    chk1("s5_post_reset_iresp", bus.icache_pmem_resp, 1'b1);
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    @(negedge clk);

    // 6: D withdraws while granted; last_served stays I, so the next tie goes to D
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h4000;
    @(negedge clk); #1;
    chk1("s6_granted_write", bus.pmem_write, 1'b1);
    @(negedge clk);
    bus.dcache_pmem_write = 1'b0;
    #1;
    chk1("s6_withdraw_write", bus.pmem_write, 1'b0);
    chk1("s6_withdraw_dresp", bus.dcache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h0600;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h0700;
    #1 chk1("s6_idle_read", bus.pmem_read, 1'b0);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chka("s6_tie_addr", bus.pmem_address, 16'h0700);
    chk1("s6_tie_dresp", bus.dcache_pmem_resp, 1'b1);
    chk1("s6_tie_iresp", bus.icache_pmem_resp, 1'b0);
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    #1 chk1("s6_release_read", bus.pmem_read, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
